// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Arbitrates two requesters onto one shared external ALU.
//            Each accepted operation completes two cycles after acceptance.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int PRIO_FIXED = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req1_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req0_op,
    input  logic [3:0]  req1_op,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp0_result,
    output logic [31:0] rsp1_result,
    output logic        rsp0_zero,
    output logic        rsp1_zero,
    output logic        rsp0_err,
    output logic        rsp1_err,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    output logic        busy
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    localparam logic [3:0] c_OP_AND  = 4'd0;
    localparam logic [3:0] c_OP_OR   = 4'd1;
    localparam logic [3:0] c_OP_ADD  = 4'd2;
    localparam logic [3:0] c_OP_SUB  = 4'd6;
    localparam logic [3:0] c_OP_SLTU = 4'd7;

    logic [1:0]  r_state;
    logic        r_last_grant;
    logic        r_owner;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [3:0]  r_op;

    logic        r_rsp0_valid;
    logic        r_rsp1_valid;
    logic [31:0] r_rsp0_result;
    logic [31:0] r_rsp1_result;
    logic        r_rsp0_zero;
    logic        r_rsp1_zero;
    logic        r_rsp0_err;
    logic        r_rsp1_err;

    logic        w_idle;
    logic        w_grant;
    logic        w_accept;
    logic        w_supported;
    logic [31:0] w_result;
    logic        w_zero;

    // Round-robin ties go to whichever requester was not granted last.
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = (PRIO_FIXED != 0) ? 1'b0 : ~r_last_grant;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
    end

    assign w_idle     = (r_state == c_IDLE);
    assign req0_ready = w_idle && req0_valid && !w_grant;
    assign req1_ready = w_idle && req1_valid && w_grant;
    assign w_accept   = req0_ready || req1_ready;

    always_comb begin
        case (r_op)
            c_OP_AND, c_OP_OR, c_OP_ADD, c_OP_SUB, c_OP_SLTU: w_supported = 1'b1;
            default:                                          w_supported = 1'b0;
        endcase
    end

    // An unsupported op never looks at the ALU: result 0 with zero set.
    assign w_result = w_supported ? alu_out : 32'd0;
    assign w_zero   = w_supported ? alu_zero : 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_last_grant  <= 1'b1;
            r_owner       <= 1'b0;
            r_a           <= 32'd0;
            r_b           <= 32'd0;
            r_op          <= 4'd0;
            r_rsp0_valid  <= 1'b0;
            r_rsp1_valid  <= 1'b0;
            r_rsp0_result <= 32'd0;
            r_rsp1_result <= 32'd0;
            r_rsp0_zero   <= 1'b0;
            r_rsp1_zero   <= 1'b0;
            r_rsp0_err    <= 1'b0;
            r_rsp1_err    <= 1'b0;
        end else begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_a          <= w_grant ? req1_a  : req0_a;
                        r_b          <= w_grant ? req1_b  : req0_b;
                        r_op         <= w_grant ? req1_op : req0_op;
                        r_owner      <= w_grant;
                        r_last_grant <= w_grant;
                        r_state      <= c_EXEC;
                    end
                end
                c_EXEC: begin
                    if (r_owner) begin
                        r_rsp1_result <= w_result;
                        r_rsp1_zero   <= w_zero;
                        r_rsp1_err    <= ~w_supported;
                        r_rsp1_valid  <= 1'b1;
                    end else begin
                        r_rsp0_result <= w_result;
                        r_rsp0_zero   <= w_zero;
                        r_rsp0_err    <= ~w_supported;
                        r_rsp0_valid  <= 1'b1;
                    end
                    r_state <= c_RESP;
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign alu_a       = r_a;
    assign alu_b       = r_b;
    assign alu_op      = r_op;
    assign busy        = !w_idle;

    assign rsp0_valid  = r_rsp0_valid;
    assign rsp1_valid  = r_rsp1_valid;
    assign rsp0_result = r_rsp0_result;
    assign rsp1_result = r_rsp1_result;
    assign rsp0_zero   = r_rsp0_zero;
    assign rsp1_zero   = r_rsp1_zero;
    assign rsp0_err    = r_rsp0_err;
    assign rsp1_err    = r_rsp1_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Scoreboard bench for alu_arbiter; instance 0 round-robin,
//            instance 1 fixed priority, both fed the same requests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    typedef struct {
        int          inst;
        bit          id;
        logic [31:0] res;
        bit          zero;
        bit          err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;

    logic        rdy0 [2];
    logic        rdy1 [2];
    logic        rv   [2][2];
    logic [31:0] rr   [2][2];
    logic        rz   [2][2];
    logic        re   [2][2];
    logic [31:0] aa   [2];
    logic [31:0] ab   [2];
    logic [3:0]  aop  [2];
    logic [31:0] aout [2];
    logic        azero[2];
    logic        bsy  [2];

    exp_t        sb[$];
    logic [31:0] mres [2][2];
    logic        mz   [2][2];
    logic        me   [2][2];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External ALU model; unsupported codes return junk the DUT must ignore.
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd7:    return (a < b) ? 32'd1 : 32'd0;
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_dut
        assign aout[k]  = alu_f(aa[k], ab[k], aop[k]);
        assign azero[k] = (aout[k] == 32'd0);
        alu_arbiter #(.PRIO_FIXED(k)) u_dut (
            .clk         (clk),
            .reset       (reset),
            .req0_valid  (req0_valid),
            .req1_valid  (req1_valid),
            .req0_a      (req0_a),
            .req0_b      (req0_b),
            .req1_a      (req1_a),
            .req1_b      (req1_b),
            .req0_op     (req0_op),
            .req1_op     (req1_op),
            .req0_ready  (rdy0[k]),
            .req1_ready  (rdy1[k]),
            .rsp0_valid  (rv[k][0]),
            .rsp1_valid  (rv[k][1]),
            .rsp0_result (rr[k][0]),
            .rsp1_result (rr[k][1]),
            .rsp0_zero   (rz[k][0]),
            .rsp1_zero   (rz[k][1]),
            .rsp0_err    (re[k][0]),
            .rsp1_err    (re[k][1]),
            .alu_a       (aa[k]),
            .alu_b       (ab[k]),
            .alu_op      (aop[k]),
            .alu_out     (aout[k]),
            .alu_zero    (azero[k]),
            .busy        (bsy[k])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit id, input bit v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] op);
        if (id) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end
    endtask

    task automatic push(input int inst, input bit id, input logic [31:0] res,
                        input bit zero, input bit err, input int at);
        exp_t e;
        e.inst = inst; e.id = id; e.res = res; e.zero = zero; e.err = err; e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic chk_reset_state();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset_busy%0d", k), {31'd0, bsy[k]}, 32'd0);
            chk($sformatf("reset_alu_a%0d", k), aa[k], 32'd0);
            chk($sformatf("reset_alu_b%0d", k), ab[k], 32'd0);
            chk($sformatf("reset_alu_op%0d", k), {28'd0, aop[k]}, 32'd0);
            chk($sformatf("reset_ready%0d", k), {30'd0, rdy1[k], rdy0[k]}, 32'd0);
        end
    endtask

    // Single request; valid is held through EXEC/RESP with scrambled operands,
    // optionally with the other requester raising and dropping valid meanwhile.
    task automatic do_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [31:0] er, input bit ez,
                         input bit ee, input bit blip);
        step();
        drive(id, 1'b1, a, b, op);
        for (int k = 0; k < 2; k++) push(k, id, er, ez, ee, cyc + 2);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("accept_ready%0d", k), {30'd0, rdy1[k], rdy0[k]}, id ? 32'd2 : 32'd1);
            chk($sformatf("accept_busy%0d", k), {31'd0, bsy[k]}, 32'd0);
        end
        step();
        drive(id, 1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A, 4'hF);
        if (blip) drive(!id, 1'b1, 32'h11111111, 32'h22222222, 4'd2);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("exec_alu_a%0d", k), aa[k], a);
            chk($sformatf("exec_alu_b%0d", k), ab[k], b);
            chk($sformatf("exec_alu_op%0d", k), {28'd0, aop[k]}, {28'd0, op});
            chk($sformatf("exec_ready%0d", k), {30'd0, rdy1[k], rdy0[k]}, 32'd0);
            chk($sformatf("exec_busy%0d", k), {31'd0, bsy[k]}, 32'd1);
        end
        step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("resp_ready%0d", k), {30'd0, rdy1[k], rdy0[k]}, 32'd0);
            chk($sformatf("resp_busy%0d", k), {31'd0, bsy[k]}, 32'd1);
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    // Monitor: pops the scoreboard on every response pulse; otherwise
    // requires each requester's rsp outputs to hold their last values.
    always @(negedge clk) begin
        int   idx;
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int n = 0; n < 2; n++) begin
                    checks++;
                    if (rv[k][n] !== 1'b0 || rr[k][n] !== 32'd0 || rz[k][n] !== 1'b0 || re[k][n] !== 1'b0) begin
                        errors++;
                        $display("FAIL rsp_in_reset inst%0d req%0d: got valid=%b result=%h zero=%b err=%b, expected all 0",
                                 k, n, rv[k][n], rr[k][n], rz[k][n], re[k][n]);
                    end
                    mres[k][n] = 32'd0; mz[k][n] = 1'b0; me[k][n] = 1'b0;
                end
            end else begin
                for (int n = 0; n < 2; n++) begin
                    if (rv[k][n] === 1'b1) begin
                        idx = -1;
                        for (int i = 0; i < sb.size(); i++)
                            if (idx < 0 && sb[i].inst == k) idx = i;
                        checks++;
                        if (idx < 0) begin
                            errors++;
                            $display("FAIL rsp_unexpected inst%0d req%0d: got valid=1 at cycle %0d, expected no pulse",
                                     k, n, cyc);
                        end else begin
                            e = sb[idx];
                            sb.delete(idx);
                            if (e.id != n || e.cyc != cyc || rr[k][n] !== e.res ||
                                rz[k][n] !== e.zero || re[k][n] !== e.err) begin
                                errors++;
                                $display("FAIL rsp_pop inst%0d: got req%0d result=%h zero=%b err=%b cycle=%0d, expected req%0d result=%h zero=%b err=%b cycle=%0d",
                                         k, n, rr[k][n], rz[k][n], re[k][n], cyc,
                                         e.id, e.res, e.zero, e.err, e.cyc);
                            end
                            mres[k][e.id] = e.res; mz[k][e.id] = e.zero; me[k][e.id] = e.err;
                        end
                    end else begin
                        checks++;
                        if (rv[k][n] !== 1'b0 || rr[k][n] !== mres[k][n] ||
                            rz[k][n] !== mz[k][n] || re[k][n] !== me[k][n]) begin
                            errors++;
                            $display("FAIL rsp_hold inst%0d req%0d: got valid=%b result=%h zero=%b err=%b, expected valid=0 result=%h zero=%b err=%b",
                                     k, n, rv[k][n], rr[k][n], rz[k][n], re[k][n],
                                     mres[k][n], mz[k][n], me[k][n]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
        step();
        step();
        @(negedge clk);
        chk_reset_state();
        step();
        reset = 1'b0;

        //     id    a             b             op    result        z     err   blip
        do_op(1'b0, 32'd5,        32'd3,        4'd2, 32'd8,        1'b0, 1'b0, 1'b0);
        do_op(1'b1, 32'h1234,     32'h1234,     4'd6, 32'd0,        1'b1, 1'b0, 1'b1);
        do_op(1'b1, 32'd1,        32'd2,        4'd7, 32'd1,        1'b0, 1'b0, 1'b0);
        do_op(1'b0, 32'd7,        32'd9,        4'd3, 32'd0,        1'b1, 1'b1, 1'b0);
        do_op(1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 4'd0, 32'h0F000F00, 1'b0, 1'b0, 1'b1);
        do_op(1'b1, 32'h00000011, 32'h00000100, 4'd1, 32'h00000111, 1'b0, 1'b0, 1'b0);
        do_op(1'b0, 32'h80000000, 32'd1,        4'd7, 32'd0,        1'b1, 1'b0, 1'b0);
        do_op(1'b1, 32'hFFFFFFFF, 32'd1,        4'd2, 32'd0,        1'b1, 1'b0, 1'b0);
        do_op(1'b0, 32'd3,        32'd5,        4'd6, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        do_op(1'b1, 32'd4,        32'd4,        4'd15, 32'd0,       1'b1, 1'b1, 1'b0);

        // Reset pulsed while an accepted op is in EXEC: no response may follow.
        step();
        drive(1'b0, 1'b1, 32'd100, 32'd23, 4'd2);
        @(negedge clk);
        chk("midrst_accept", {30'd0, rdy1[0], rdy0[0]}, 32'd1);
        step();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        #1 reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("midrst_busy%0d", k), {31'd0, bsy[k]}, 32'd0);
            chk($sformatf("midrst_alu_a%0d", k), aa[k], 32'd0);
            chk($sformatf("midrst_rsp0_result%0d", k), rr[k][0], 32'd0);
            chk($sformatf("midrst_rsp1_err%0d", k), {31'd0, re[k][1]}, 32'd0);
        end
        @(negedge clk);
        #2 reset = 1'b0;
        step();
        @(negedge clk);
        chk("midrst_idle_busy", {31'd0, bsy[0]}, 32'd0);
        do_op(1'b0, 32'd100, 32'd23, 4'd2, 32'd123, 1'b0, 1'b0, 1'b0);

        // Both requesters valid continuously from reset.
        step();
        reset = 1'b1;
        step();
        step();
        @(negedge clk);
        chk_reset_state();
        step();
        reset = 1'b0;
        drive(1'b0, 1'b1, 32'd10, 32'd3, 4'd2);
        drive(1'b1, 1'b1, 32'd10, 32'd3, 4'd6);
        for (int g = 0; g < 4; g++) begin
            if (g > 0) step();
            @(negedge clk);
            chk($sformatf("tie_rr_grant%0d", g), {30'd0, rdy1[0], rdy0[0]}, (g % 2) ? 32'd2 : 32'd1);
            chk($sformatf("tie_fix_grant%0d", g), {30'd0, rdy1[1], rdy0[1]}, 32'd1);
            push(0, (g % 2) == 1, (g % 2) ? 32'd7 : 32'd13, 1'b0, 1'b0, cyc + 2);
            push(1, 1'b0, 32'd13, 1'b0, 1'b0, cyc + 2);
            for (int s = 0; s < 2; s++) begin
                step();
                @(negedge clk);
                chk($sformatf("tie_hold_rr%0d_%0d", g, s), {30'd0, rdy1[0], rdy0[0]}, 32'd0);
                chk($sformatf("tie_hold_fix%0d_%0d", g, s), {30'd0, rdy1[1], rdy0[1]}, 32'd0);
            end
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);

        repeat (4) step();
        @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter PRIO_FIXED, default 0: 0 = round-robin arbitration; 1 = requester 0 always wins ties.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0_valid, req1_valid  input  1 each  requester N presents an operation.
REQ-005 req0_a, req0_b, req1_a, req1_b  input  32 each  operands A/B of requester N.
REQ-006 req0_op, req1_op  input  4 each  ALU op code of requester N (0 AND, 1 OR, 2 ADD, 6 SUB, 7 set-less-than unsigned).
REQ-007 req0_ready, req1_ready  output  1 each  requester N's operation is accepted this cycle when valid and ready are both high.
REQ-008 rsp0_valid, rsp1_valid  output  1 each  one-cycle pulse: result for requester N is valid.
REQ-009 rsp0_result, rsp1_result  output  32 each  captured ALU result.
REQ-010 rsp0_zero, rsp1_zero  output  1 each  captured ALU zero flag.
REQ-011 rsp0_err, rsp1_err  output  1 each  op code was unsupported.
REQ-012 alu_a, alu_b  output  32 each  operands driven to the shared ALU.
REQ-013 alu_op  output  4  op code driven to the shared ALU.
REQ-014 alu_out  input  32  ALU result; alu_zero  input  1  ALU zero flag.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states IDLE, EXEC, RESP; IDLE -> EXEC on acceptance; EXEC -> RESP unconditionally; RESP -> IDLE unconditionally.
REQ-017 Ready is combinational: reqN_ready = (state == IDLE) and grant==N and reqN_valid; never both high in one cycle.
REQ-018 Grant with one valid requester: that requester.
REQ-019 Grant with both valid, PRIO_FIXED=0: requester other than last_grant; PRIO_FIXED=1: requester 0.
REQ-020 last_grant updates only on acceptance; valid without acceptance leaves it unchanged.
REQ-021 On acceptance (cycle N), a, b, op and owner ID are registered; alu_a/alu_b/alu_op are driven solely from these registers.
REQ-022 Supported op = {0,1,2,6,7}; the supported check is made on the registered op.
REQ-023 In EXEC (cycle N+1), for a supported op, alu_out and alu_zero are captured into the owner's rsp registers at the end of the cycle.
REQ-024 For an unsupported op: owner's result = 0, zero = 1, err = 1; alu_out is ignored.
REQ-025 rspN_valid is high only in RESP (cycle N+2), for the owner only, for exactly one cycle; fixed latency is 2 cycles from acceptance.
REQ-026 No response backpressure; the requester must sample on the pulse.
REQ-027 rspN_result/zero/err hold their last values until the next response to the same requester.
REQ-028 Throughput is one operation per 3 cycles; no acceptance in EXEC or RESP even if valid is held.
REQ-029 A requester dropping valid before acceptance cancels its request with no side effect.
REQ-030 Operand changes after acceptance do not affect the in-flight operation.
REQ-031 The non-owner's rsp outputs are unchanged during the operation.

Reset
REQ-032 While reset is high: state = IDLE, last_grant = 1 (requester 0 wins the first tie), busy = 0.
REQ-033 While reset is high: all rsp valid/result/zero/err = 0; alu_a = alu_b = 0, alu_op = 0.
REQ-034 Reset asserted in EXEC or RESP discards the in-flight operation: no rsp_valid pulse is issued and no rsp register is updated.

Verification
REQ-035 Single op: req0 a=5, b=3, op=2 at cycle 0 -> req0_ready=1 at cycle 0; alu_a=5/alu_op=2 at cycle 1; rsp0_valid=1, result=8, zero=0 at cycle 2 only.
REQ-036 Tie, round-robin: both valid continuously from reset -> grants alternate 0,1,0,1 at cycles 0,3,6,9; PRIO_FIXED=1 -> requester 0 at every grant.
REQ-037 SUB to zero and SLT: req1 a=b=0x1234, op=6 -> rsp1_result=0, zero=1; a=1, b=2, op=7 -> result=1, zero=0.
REQ-038 Unsupported op=3 from req0 -> rsp0_err=1, result=0, zero=1 at latency 2; a following valid op clears err.
REQ-039 Reset mid-operation: reset pulsed in EXEC -> no rsp pulse; busy=0 and outputs zero immediately (asynchronously); next request is accepted normally.
REQ-040 Operand hold: req0 changes a/b/op in the cycle after acceptance -> result reflects the accepted values; req1 outputs unchanged throughout.
